// File: rtl/dff_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_ram_pkg
// Description : Shared geometry and word type for the 8x72 flip-flop RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_ram_pkg;

   localparam int DATA_W = 72;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef logic [DATA_W-1:0] word_t;

endpackage : dff_ram_pkg
`default_nettype wire

// File: rtl/dff_ram_row.sv
`default_nettype none
// ============================================================================
// Module      : dff_ram_row
// Description : One DATA_W-wide storage word with write enable and async clear.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_ram_row
   import dff_ram_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  we,
   input  word_t d,
   output word_t q
);

   word_t r_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word <= '0;
      end else if (we) begin
         r_word <= d;
      end
   end

   assign q = r_word;

endmodule : dff_ram_row
`default_nettype wire

// File: rtl/dff_ram_8x72.sv
`default_nettype none
// ============================================================================
// Module      : dff_ram_8x72
// Description : 8x72 flip-flop RAM, single shared address, wr=0 writes,
//               wr=1 reads into a registered rdata. Optional build macro
//               DFF_RAM_WR_FWD_EN makes write cycles also load rdata.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_ram_8x72
   import dff_ram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [ADDR_W-1:0] address,
   input  word_t             wdata,
   output word_t             rdata
);

   logic [DEPTH-1:0] w_we;
   word_t            w_mem [DEPTH];
   word_t            r_rdata;

   // One-hot write decode: exactly one row enabled on a write cycle.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_row
         assign w_we[i] = ~wr & (address == ADDR_W'(i));

         dff_ram_row u_row (
            .clk (clk),
            .rst (rst),
            .we  (w_we[i]),
            .d   (wdata),
            .q   (w_mem[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (wr) begin
         r_rdata <= w_mem[address];
      end
`ifdef DFF_RAM_WR_FWD_EN
      else begin
         r_rdata <= wdata;
      end
`endif
   end

   assign rdata = r_rdata;

endmodule : dff_ram_8x72
`default_nettype wire

// File: tb/tb_dff_ram_8x72.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_ram_8x72
// Description : Directed self-checking bench for dff_ram_8x72.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_ram_8x72;

   logic        clk;
   logic        rst;
   logic        wr;
   logic [2:0]  address;
   logic [71:0] wdata;
   logic [71:0] rdata;

   int n_tests = 0;
   int n_fail  = 0;

   dff_ram_8x72 dut (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .address (address),
      .wdata   (wdata),
      .rdata   (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr_word(input logic [2:0] a, input logic [71:0] d);
      @(negedge clk);
      wr      = 1'b0;
      address = a;
      wdata   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic rd_word(input logic [2:0] a, input logic [71:0] exp, input string tag);
      @(negedge clk);
      wr      = 1'b1;
      address = a;
      wdata   = '0;
      @(posedge clk);
      #1;
      chk(tag, rdata, exp);
   endtask

   logic [71:0] fill [8];

   initial begin
      fill = '{72'd19, 72'd27, 72'd13, 72'd40, 72'd25, 72'd22, 72'd17, 72'd20};
      rst     = 1'b1;
      wr      = 1'b1;
      address = '0;
      wdata   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdata", rdata, 72'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         rd_word(3'(i), 72'h0, $sformatf("reset_mem%0d", i));

      for (int i = 0; i < 8; i++)
         wr_word(3'(i), fill[i]);
      for (int i = 0; i < 8; i++)
         rd_word(3'(i), fill[i], $sformatf("fill_rd%0d", i));

      wr_word(3'd5, 72'hFF_FFFF_FFFF_FFFF_FFFF);
      wr_word(3'd2, 72'h80_0000_0000_0000_0001);
      rd_word(3'd5, 72'hFF_FFFF_FFFF_FFFF_FFFF, "full_ones_a5");
      rd_word(3'd2, 72'h80_0000_0000_0000_0001, "msb_lsb_a2");
      rd_word(3'd4, 72'd25, "neighbour_a4");
      rd_word(3'd6, 72'd17, "neighbour_a6");

      wr_word(3'd3, 72'd40);
      wr_word(3'd3, 72'd99);
      rd_word(3'd3, 72'd99, "overwrite_a3");

      rd_word(3'd1, 72'd27, "pre_write_a1");
      wr_word(3'd6, 72'd55);
`ifdef DFF_RAM_WR_FWD_EN
      chk("write_fwd_rdata", rdata, 72'd55);
`else
      chk("write_hold_rdata", rdata, 72'd27);
`endif
      rd_word(3'd6, 72'd55, "written_a6");

      // Abort a write by asserting reset between edges.
      @(negedge clk);
      wr      = 1'b0;
      address = 3'd4;
      wdata   = 72'd123;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_rdata", rdata, 72'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_rdata", rdata, 72'h0);
      @(negedge clk);
      wr  = 1'b1;
      rst = 1'b0;
      rd_word(3'd4, 72'h0, "aborted_write_a4");
      rd_word(3'd1, 72'h0, "post_rst_a1");
      rd_word(3'd6, 72'h0, "post_rst_a6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_dff_ram_8x72
`default_nettype wire

// File: doc/dff_ram_8x72.md
Name: dff_ram_8x72

Overview:
- 8-entry by 72-bit register-file RAM built from flip-flops.
- One clock, one shared address, active-low write strobe `wr`, registered read port.
- Serves as a small scratch/descriptor store that needs deterministic reset contents. It sits beside the datapath, with no handshake.

Parameters:
- DATA_W, 72, word width in bits.
- DEPTH, 8, number of words.
- ADDR_W, 3, address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr  input  1  access select: 0 = write cycle, 1 = read cycle.
- address  input  ADDR_W  word index, 0..7.
- wdata  input  DATA_W  write data, sampled when wr=0.
- rdata  output  DATA_W  registered read data.

Behaviour:
- Interface fixed: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - rst=1 immediately clears all 8 words to 72'h0 and rdata to 72'h0, independent of clk.
  - Deassertion takes effect at the next rising edge.
- Write cycle: on a rising edge with wr=0, mem[address] <= wdata. The other 7 words are unchanged. rdata holds its previous value (default build).
- Read cycle: on a rising edge with wr=1, rdata <= mem[address]. Memory is unchanged. Read latency is 1 cycle: data is visible after the sampling edge.
- Read-after-write to the same address on the next edge returns the newly written data.
- All 8 addresses are valid. There is no out-of-range case and no wrap logic.
- Inputs are sampled only at rising edges. Changes between edges have no effect.
- rst asserted mid-operation aborts any write in progress. That edge's write is lost and contents read 0 afterwards.
- No simultaneous read and write exists: a single port with wr selecting the access.

Optional Feature:
- Macro DFF_RAM_WR_FWD_EN.
- Defined: on a write cycle, rdata <= wdata as well as mem[address] <= wdata (write-through), so the written value appears on rdata one cycle later.
- Undefined: rdata holds during write cycles, as described in Behaviour.
- Reset behaviour is identical in both builds.

Decomposition:
- Shared package dff_ram_pkg holds DATA_W=72, DEPTH=8, ADDR_W=3, and the typedef word_t = logic [DATA_W-1:0].
- One sub-module, dff_ram_row: a single DATA_W register with write enable and async clear. It is instantiated DEPTH times with a one-hot decode of (~wr & address match).
- The read mux and rdata register live in the top.

Test Plan:
- Reset: assert rst mid-cycle -> rdata=0 immediately. Then read addresses 0..7 with wr=1 -> each returns 72'h0.
- Fill and readback:
  - Write 19, 27, 13, 40, 25, 22, 17, 20 to addresses 0..7 (wr=0, one per cycle).
  - Then read 0..7 (wr=1) -> rdata equals 19, 27, 13, 40, 25, 22, 17, 20, each one cycle after its address edge.
- Full-width data: write 72'hFF_FFFF_FFFF_FFFF_FFFF to address 5 and 72'h80_0000_0000_0000_0001 to address 2 -> reads return exact patterns and neighbours 4/6 are unchanged.
- Overwrite: write 72'd40 to address 3, then 72'd99 to address 3, then read address 3 -> 99.
- Write does not disturb rdata:
  - Read address 1 (27), then write 72'd55 to address 6 -> rdata stays 27 (default build), or becomes 55 with DFF_RAM_WR_FWD_EN.
- Async reset during a write: assert rst between edges while wr=0, address=4, wdata=72'd123 -> address 4 reads 0 after release, and rdata is 0 during reset.
